hms_counter: RTL and testbench

HMS_COUNTER -- requirements
Module: hms_counter

---
 rtl/hms_pkg.sv | 28 ++
 rtl/hms_counter_bcd_split.sv | 17 +
 rtl/hms_counter.sv | 204 ++++++++++++++++++++
 tb/tb_hms_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// hms_pkg -- shared types and constants for the hours/minutes/seconds counter.
//   hms_t  : packed time value (hours, mins, secs), 6 bits per field
//   bcd2_t : packed two-digit BCD value (tens, units), 4 bits per digit
//   SEC_MAX, MIN_MAX : last legal value of the seconds and minutes fields
`timescale 1ns/1ps

package hms_pkg;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
  } hms_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // True when every field of t is a legal time for an hour modulus of hour_lim.
  function automatic logic hms_in_range(input hms_t t, input logic [5:0] hour_lim);
    return (t.hours < hour_lim) && (t.mins <= MIN_MAX) && (t.secs <= SEC_MAX);
  endfunction

endpackage

// File: rtl/hms_counter_bcd_split.sv
// bcd_split -- combinational binary-to-two-digit-BCD converter.
//   bin : 6-bit binary value (0..63)
//   bcd : tens = bin / 10, units = bin % 10
`timescale 1ns/1ps

module bcd_split
  import hms_pkg::*;
(
  input  logic [5:0] bin,
  output bcd2_t      bcd
);

  // A 6-bit value is at most 63, so the tens digit always fits in 4 bits.
  assign bcd.tens  = 4'(bin / 6'd10);
  assign bcd.units = 4'(bin % 6'd10);

endmodule

// File: rtl/hms_counter.sv
// hms_counter -- up/down hours:minutes:seconds counter with a clock prescaler,
// range-checked parallel load and BCD digit outputs.
//
// Parameters:
//   HOUR_MOD : hour modulus (2..60)
//   TICK_DIV : clk cycles per one-second step (>= 1)
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   run, count_up             : counting enable, direction (1 = up)
//   load, load_hour/min/sec   : single-cycle load strobe and load value
//   hour/min/sec_tens/units   : BCD digits of the current time
//   sec_pulse                 : one-cycle strobe while a fresh step is shown
//   wrap                      : one-cycle strobe on a step across the modulus
//   load_err                  : one-cycle strobe for a rejected load
// Optional feature (macro HMS_ALARM_EN):
//   alarm_set, alarm_hour/min/sec : store an alarm time (range-checked)
//   alarm_hit                     : one-cycle strobe when a step lands on it
`timescale 1ns/1ps

module hms_counter
  import hms_pkg::*;
#(
  parameter int HOUR_MOD = 24,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       count_up,
  input  logic       load,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_pulse,
  output logic       wrap,
  output logic       load_err
`ifdef HMS_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic [5:0] alarm_sec,
  output logic       alarm_hit
`endif
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    HOUR_MAX   = 6'(HOUR_MOD - 1);
  localparam logic [5:0]    HOUR_LIM   = 6'(HOUR_MOD);
  localparam hms_t          TIME_TOP   = {HOUR_MAX, MIN_MAX, SEC_MAX};
  localparam hms_t          TIME_ZERO  = '0;

  hms_t          time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;

  hms_t load_time;
  hms_t stepped;
  logic at_wrap;
  logic tick;
  logic load_ok;
  logic load_bad;
  logic step_taken;

  assign load_time  = {load_hour, load_min, load_sec};
  assign load_ok    = load && hms_in_range(load_time, HOUR_LIM);
  assign load_bad   = load && !load_ok;
  assign tick       = run && (presc_q == PRESC_LAST);
  // An accepted load swallows a coinciding step; a rejected one does not.
  assign step_taken = tick && !load_ok;

  // One-second step of the time value in the direction sampled this cycle,
  // with carry/borrow rippling secs -> mins -> hours.
  always_comb begin
    stepped = time_q;
    at_wrap = 1'b0;
    if (count_up) begin
      at_wrap = (time_q == TIME_TOP);
      if (time_q.secs != SEC_MAX) begin
        stepped.secs = time_q.secs + 6'd1;
      end else begin
        stepped.secs = '0;
        if (time_q.mins != MIN_MAX) begin
          stepped.mins = time_q.mins + 6'd1;
        end else begin
          stepped.mins  = '0;
          stepped.hours = (time_q.hours == HOUR_MAX) ? 6'd0 : time_q.hours + 6'd1;
        end
      end
    end else begin
      at_wrap = (time_q == TIME_ZERO);
      if (time_q.secs != 6'd0) begin
        stepped.secs = time_q.secs - 6'd1;
      end else begin
        stepped.secs = SEC_MAX;
        if (time_q.mins != 6'd0) begin
          stepped.mins = time_q.mins - 6'd1;
        end else begin
          stepped.mins  = MIN_MAX;
          stepped.hours = (time_q.hours == 6'd0) ? HOUR_MAX : time_q.hours - 6'd1;
        end
      end
    end
  end

`ifdef HMS_ALARM_EN
  hms_t alarm_q, alarm_d;
  logic alarm_hit_q, alarm_hit_d;
  hms_t alarm_time;
  logic alarm_ok;
  logic alarm_bad;

  assign alarm_time = {alarm_hour, alarm_min, alarm_sec};
  assign alarm_ok   = alarm_set && hms_in_range(alarm_time, HOUR_LIM);
  assign alarm_bad  = alarm_set && !alarm_ok;

  // The hit compares against the alarm already stored, so an alarm_set in the
  // same cycle as a step only takes effect from the next step onwards.
  always_comb begin
    alarm_d     = alarm_ok ? alarm_time : alarm_q;
    alarm_hit_d = step_taken && (stepped == alarm_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q     <= TIME_ZERO;
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_q     <= alarm_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`else
  logic alarm_bad;
  assign alarm_bad = 1'b0;
`endif

  // Next state: load beats step; the prescaler only moves while running,
  // but an accepted load always restarts it from zero.
  always_comb begin
    time_d      = time_q;
    presc_d     = presc_q;
    sec_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    load_err_d  = load_bad || alarm_bad;
    if (load_ok) begin
      time_d  = load_time;
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        time_d      = stepped;
        sec_pulse_d = 1'b1;
        wrap_d      = at_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q      <= TIME_TOP;
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      time_q      <= time_d;
      presc_q     <= presc_d;
      sec_pulse_q <= sec_pulse_d;
      wrap_q      <= wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign sec_pulse = sec_pulse_q;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

  // All three fields come straight from the same register, so digits never skew.
  bcd2_t hour_bcd, min_bcd, sec_bcd;

  bcd_split u_hour_bcd (.bin(time_q.hours), .bcd(hour_bcd));
  bcd_split u_min_bcd  (.bin(time_q.mins),  .bcd(min_bcd));
  bcd_split u_sec_bcd  (.bin(time_q.secs),  .bcd(sec_bcd));

  assign hour_tens  = hour_bcd.tens;
  assign hour_units = hour_bcd.units;
  assign min_tens   = min_bcd.tens;
  assign min_units  = min_bcd.units;
  assign sec_tens   = sec_bcd.tens;
  assign sec_units  = sec_bcd.units;

endmodule

// File: tb/tb_hms_counter.sv
// tb_hms_counter -- directed self-checking bench for hms_counter with
// HOUR_MOD=24 and TICK_DIV=4. Each step drives inputs, pushes the expected
// time/flags to a scoreboard queue, clocks once and pops/compares.
// Alarm scenarios are included when HMS_ALARM_EN is defined.
`timescale 1ns/1ps

module tb_hms_counter;

  typedef struct {
    string tag;
    int    h;
    int    m;
    int    s;
    bit    p;
    bit    w;
    bit    e;
    bit    a;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       run;
  logic       count_up;
  logic       load;
  logic [5:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic       sec_pulse;
  logic       wrap;
  logic       load_err;
  logic       alarm_hit_obs;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

`ifdef HMS_ALARM_EN
  logic       alarm_set;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] alarm_sec;
`else
  assign alarm_hit_obs = 1'b0;
`endif

  hms_counter #(.HOUR_MOD(24), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .count_up   (count_up),
    .load       (load),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .sec_pulse  (sec_pulse),
    .wrap       (wrap),
    .load_err   (load_err)
`ifdef HMS_ALARM_EN
    ,
    .alarm_set  (alarm_set),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .alarm_hit  (alarm_hit_obs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit rst, input bit run_i, input bit up_i,
                               input bit ld, input int lh, input int lm, input int ls);
    reset     = rst;
    run       = run_i;
    count_up  = up_i;
    load      = ld;
    load_hour = 6'(lh);
    load_min  = 6'(lm);
    load_sec  = 6'(ls);
  endtask

`ifdef HMS_ALARM_EN
  task automatic setAlarm(input bit set, input int h, input int m, input int s);
    alarm_set  = set;
    alarm_hour = 6'(h);
    alarm_min  = 6'(m);
    alarm_sec  = 6'(s);
  endtask
`endif

  task automatic checkOutput();
    exp_t        x;
    logic [23:0] got_d, exp_d;
    logic [3:0]  got_f, exp_f;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, required one entry");
      return;
    end
    x     = sb.pop_front();
    exp_d = {4'(x.h / 10), 4'(x.h % 10), 4'(x.m / 10), 4'(x.m % 10),
             4'(x.s / 10), 4'(x.s % 10)};
    got_d = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
    exp_f = {x.p, x.w, x.e, x.a};
    got_f = {sec_pulse, wrap, load_err, alarm_hit_obs};
    checks++;
    assert (got_d === exp_d) else begin
      errors++;
      $error("[TB] FAIL %s digits: got %h required %h", x.tag, got_d, exp_d);
    end
    checks++;
    assert (got_f === exp_f) else begin
      errors++;
      $error("[TB] FAIL %s flags(pulse,wrap,err,hit): got %b required %b", x.tag, got_f, exp_f);
    end
  endtask

  // Push the expectation for the next edge, clock once, then compare.
  task automatic expectStep(input string tag, input int h, input int m, input int s,
                            input bit p, input bit w, input bit e, input bit a);
    exp_t x;
    x.tag = tag; x.h = h; x.m = m; x.s = s;
    x.p = p; x.w = w; x.e = e; x.a = a;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
`ifdef HMS_ALARM_EN
    setAlarm(0, 0, 0, 0);
`endif
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    expectStep("reset", 23, 59, 59, 0, 0, 0, 0);
    expectStep("reset_hold", 23, 59, 59, 0, 0, 0, 0);

    // Down counting from reset: one step every 4 cycles.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      expectStep("down_tick", 23, 59, 59 - i / 4, (i % 4) == 0, 0, 0, 0);

    // Load 00:00:00 and borrow through every field.
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    expectStep("load_zero", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (3) expectStep("pre_wrap_dn", 0, 0, 0, 0, 0, 0, 0);
    expectStep("wrap_dn", 23, 59, 59, 1, 1, 0, 0);
    expectStep("wrap_dn_clear", 23, 59, 59, 0, 0, 0, 0);

    // Up counting across the top, then a minute carry.
    applyStimulus(0, 1, 1, 1, 23, 59, 59);
    expectStep("load_max", 23, 59, 59, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (3) expectStep("pre_wrap_up", 23, 59, 59, 0, 0, 0, 0);
    expectStep("wrap_up", 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 12, 9, 59);
    expectStep("load_12_09_59", 12, 9, 59, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (3) expectStep("pre_carry", 12, 9, 59, 0, 0, 0, 0);
    expectStep("min_carry", 12, 10, 0, 1, 0, 0, 0);

    // Rejected loads keep the prescaler moving; accepted load eats the step.
    applyStimulus(0, 1, 1, 1, 24, 0, 0);
    expectStep("rej_hour", 12, 10, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 5, 60, 0);
    expectStep("rej_min", 12, 10, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    expectStep("err_clear", 12, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 10, 0, 0);
    expectStep("load_on_step", 10, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (3) expectStep("after_load", 10, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 60);
    expectStep("rej_on_step", 10, 0, 1, 1, 0, 1, 0);

    // Pause mid-prescale; the phase must resume where it stopped.
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (2) expectStep("pre_pause", 10, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (10) expectStep("paused", 10, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    expectStep("resume", 10, 0, 1, 0, 0, 0, 0);
    expectStep("resume_step", 10, 0, 2, 1, 0, 0, 0);
    expectStep("mid_count", 10, 0, 2, 0, 0, 0, 0);

    // Reset beats a coinciding load and clears the prescaler.
    applyStimulus(1, 1, 1, 1, 5, 5, 5);
    expectStep("reset_mid", 23, 59, 59, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (3) expectStep("post_reset", 23, 59, 59, 0, 0, 0, 0);
    expectStep("post_reset_step", 23, 59, 58, 1, 0, 0, 0);

`ifdef HMS_ALARM_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    setAlarm(1, 0, 0, 60);
    expectStep("alarm_rej", 23, 59, 58, 0, 0, 1, 0);
    setAlarm(1, 0, 0, 5);
    expectStep("alarm_set", 23, 59, 58, 0, 0, 0, 0);
    setAlarm(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 7);
    expectStep("load_7", 0, 0, 7, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (3) expectStep("alarm_wait", 0, 0, 7, 0, 0, 0, 0);
    expectStep("step_6", 0, 0, 6, 1, 0, 0, 0);
    repeat (3) expectStep("alarm_wait", 0, 0, 6, 0, 0, 0, 0);
    expectStep("alarm_hit", 0, 0, 5, 1, 0, 0, 1);
    expectStep("alarm_clear", 0, 0, 5, 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
